// File: rtl/l2_read_arbiter_if.sv
// Generic miss/read channel: the master raises read_en with addr, the slave answers with stall/block.
// One instance each for the icache, the dcache and the L2 side of l2_read_arbiter.
interface l2_read_arbiter_if #(
    parameter int ADDR_W  = 32,
    parameter int BLOCK_W = 256
);
    logic               read_en;
    logic [ADDR_W-1:0]  addr;
    logic               stall;
    logic [BLOCK_W-1:0] block;

    modport master (
        output read_en,
        output addr,
        input  stall,
        input  block
    );

    modport slave (
        input  read_en,
        input  addr,
        output stall,
        output block
    );
endinterface

// File: rtl/l2_read_arbiter.sv
// Shares the single L2 read port between icache and dcache misses; dcache wins unless icache starved.
// Optional macro L2_ARB_PERF_EN adds 32-bit grant and wait-cycle performance counters.
module l2_read_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int BLOCK_W    = 256,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    l2_read_arbiter_if.slave   ic_if,
    l2_read_arbiter_if.slave   dc_if,
    l2_read_arbiter_if.master  l2_if
`ifdef L2_ARB_PERF_EN
    ,
    output logic [31:0]        perf_ic_grants_o,
    output logic [31:0]        perf_dc_grants_o,
    output logic [31:0]        perf_wait_cycles_o
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1
    } state_e;

    typedef enum logic {
        GRANT_DC = 1'b0,
        GRANT_IC = 1'b1
    } grant_e;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_e             state_q, state_d;
    grant_e             grant_q, grant_d;
    logic [3:0]         starve_cnt_q, starve_cnt_d;
    logic               l2_read_en_q, l2_read_en_d;
    logic [ADDR_W-1:0]  l2_addr_q, l2_addr_d;

    logic               ic_req, dc_req;
    logic               ic_starved, dc_wins, ic_wins;
    logic               l2_done;

    assign ic_req     = ic_if.read_en;
    assign dc_req     = dc_if.read_en;
    // The icache only overrides dcache priority once it has lost STARVE_MAX grants in a row.
    assign ic_starved = ic_req && (starve_cnt_q == STARVE_LIM);
    assign dc_wins    = dc_req && !ic_starved;
    assign ic_wins    = ic_req && !dc_wins;
    assign l2_done    = (state_q == BUSY) && !l2_if.stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= GRANT_DC;
            starve_cnt_q <= 4'd0;
            l2_read_en_q <= 1'b0;
            l2_addr_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            starve_cnt_q <= starve_cnt_d;
            l2_read_en_q <= l2_read_en_d;
            l2_addr_q    <= l2_addr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        starve_cnt_d = starve_cnt_q;
        l2_read_en_d = l2_read_en_q;
        l2_addr_d    = l2_addr_q;
        case (state_q)
            IDLE: begin
                l2_read_en_d = 1'b0;
                if (dc_wins) begin
                    state_d      = BUSY;
                    grant_d      = GRANT_DC;
                    l2_read_en_d = 1'b1;
                    l2_addr_d    = dc_if.addr;
                    if (ic_req) begin
                        starve_cnt_d = (starve_cnt_q >= STARVE_LIM) ? STARVE_LIM
                                                                    : starve_cnt_q + 4'd1;
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end else if (ic_wins) begin
                    state_d      = BUSY;
                    grant_d      = GRANT_IC;
                    l2_read_en_d = 1'b1;
                    l2_addr_d    = ic_if.addr;
                    starve_cnt_d = 4'd0;
                end
            end
            BUSY: begin
                // The L2 request is never withdrawn early, even if the requester gave up.
                l2_read_en_d = 1'b1;
                if (!l2_if.stall) begin
                    state_d      = IDLE;
                    l2_read_en_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                l2_read_en_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        ic_if.stall = 1'b1;
        dc_if.stall = 1'b1;
        if (l2_done) begin
            if (grant_q == GRANT_IC) begin
                ic_if.stall = 1'b0;
            end else begin
                dc_if.stall = 1'b0;
            end
        end
    end

    assign ic_if.block = l2_if.block;
    assign dc_if.block = l2_if.block;
    assign l2_if.read_en = l2_read_en_q;
    assign l2_if.addr    = l2_addr_q;

`ifdef L2_ARB_PERF_EN
    logic        ic_served, dc_served;
    logic [31:0] wait_inc;
    logic [31:0] perf_ic_grants_q, perf_dc_grants_q, perf_wait_cycles_q;

    // A requester counts as served in its grant cycle and for the whole BUSY phase it owns.
    assign ic_served = ((state_q == IDLE) && ic_wins) || ((state_q == BUSY) && (grant_q == GRANT_IC));
    assign dc_served = ((state_q == IDLE) && dc_wins) || ((state_q == BUSY) && (grant_q == GRANT_DC));
    assign wait_inc  = 32'(ic_req && !ic_served) + 32'(dc_req && !dc_served);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ic_grants_q   <= 32'd0;
            perf_dc_grants_q   <= 32'd0;
            perf_wait_cycles_q <= 32'd0;
        end else begin
            if ((state_q == IDLE) && ic_wins) begin
                perf_ic_grants_q <= perf_ic_grants_q + 32'd1;
            end
            if ((state_q == IDLE) && dc_wins) begin
                perf_dc_grants_q <= perf_dc_grants_q + 32'd1;
            end
            perf_wait_cycles_q <= perf_wait_cycles_q + wait_inc;
        end
    end

    assign perf_ic_grants_o   = perf_ic_grants_q;
    assign perf_dc_grants_o   = perf_dc_grants_q;
    assign perf_wait_cycles_o = perf_wait_cycles_q;
`endif

endmodule

// File: tb/tb_l2_read_arbiter.sv
// Scoreboard bench for l2_read_arbiter: a transaction-level model predicts L2 requests and stall pulses,
// a separate monitor compares them every cycle; directed scenarios precede a randomized phase.
module tb_l2_read_arbiter;

    localparam int ADDR_W     = 32;
    localparam int BLOCK_W    = 256;
    localparam int STARVE_MAX = 4;

    typedef logic [BLOCK_W-1:0] wide_t;

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] addr;
    } reqExp_t;

    typedef struct {
        int    cyc;
        wide_t block;
    } doneExp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    l2_read_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) icBus ();
    l2_read_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) dcBus ();
    l2_read_arbiter_if #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W)) l2Bus ();

`ifdef L2_ARB_PERF_EN
    logic [31:0] perfIc, perfDc, perfWait;
`endif

    l2_read_arbiter #(
        .ADDR_W     (ADDR_W),
        .BLOCK_W    (BLOCK_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ic_if (icBus),
        .dc_if (dcBus),
        .l2_if (l2Bus)
`ifdef L2_ARB_PERF_EN
        ,
        .perf_ic_grants_o   (perfIc),
        .perf_dc_grants_o   (perfDc),
        .perf_wait_cycles_o (perfWait)
`endif
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    bit randOn     = 1'b0;
    bit icSawDone  = 1'b0;
    bit dcSawDone  = 1'b0;

    reqExp_t  expL2[$];
    doneExp_t expIc[$];
    doneExp_t expDc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input wide_t act, input wide_t exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic wide_t randBlock();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    // One call drives one full cycle of inputs, changed just after the rising edge.
    task automatic applyStimulus(input bit icEn, input logic [ADDR_W-1:0] icAddr,
                                 input bit dcEn, input logic [ADDR_W-1:0] dcAddr,
                                 input bit l2Stall);
        @(posedge clk);
        #1;
        icBus.read_en = icEn;
        icBus.addr    = icAddr;
        dcBus.read_en = dcEn;
        dcBus.addr    = dcAddr;
        l2Bus.stall   = l2Stall;
        l2Bus.block   = randBlock();
    endtask

    // Reference model: one L2 port, one outstanding miss, dcache preferred until the icache
    // has been passed over STARVE_MAX times in a row.
    bit mBusy;
    bit mOwnerIc;
    int mPassedOver;
    always @(negedge clk) begin
        reqExp_t  r;
        doneExp_t d;
        if (!rst_n) begin
            mBusy       = 1'b0;
            mOwnerIc    = 1'b0;
            mPassedOver = 0;
            expL2.delete();
            expIc.delete();
            expDc.delete();
        end else if (mBusy) begin
            if (!l2Bus.stall) begin
                d.cyc   = cyc;
                d.block = l2Bus.block;
                if (mOwnerIc) expIc.push_back(d);
                else          expDc.push_back(d);
                mBusy = 1'b0;
            end
        end else if (dcBus.read_en && !(icBus.read_en && mPassedOver == STARVE_MAX)) begin
            r.cyc  = cyc + 1;
            r.addr = dcBus.addr;
            expL2.push_back(r);
            mOwnerIc    = 1'b0;
            mBusy       = 1'b1;
            mPassedOver = icBus.read_en ? ((mPassedOver < STARVE_MAX) ? mPassedOver + 1 : STARVE_MAX) : 0;
        end else if (icBus.read_en) begin
            r.cyc  = cyc + 1;
            r.addr = icBus.addr;
            expL2.push_back(r);
            mOwnerIc    = 1'b1;
            mBusy       = 1'b1;
            mPassedOver = 0;
        end
    end

    // Monitor: compares DUT outputs against the model's predictions once per cycle.
    bit                expInFlight = 1'b0;
    logic [ADDR_W-1:0] curAddr     = '0;
    always @(negedge clk) begin
        reqExp_t  r;
        doneExp_t d;
        bit       icPulse, dcPulse;
        #1;
        if (!rst_n) begin
            checkOutput("rst_l2_read_en", wide_t'(l2Bus.read_en), wide_t'(1'b0));
            checkOutput("rst_l2_addr", wide_t'(l2Bus.addr), wide_t'(0));
            checkOutput("rst_ic_stall", wide_t'(icBus.stall), wide_t'(1'b1));
            checkOutput("rst_dc_stall", wide_t'(dcBus.stall), wide_t'(1'b1));
            expInFlight = 1'b0;
            icSawDone   = 1'b0;
            dcSawDone   = 1'b0;
        end else begin
            if (expL2.size() > 0 && expL2[0].cyc == cyc) begin
                r           = expL2.pop_front();
                curAddr     = r.addr;
                expInFlight = 1'b1;
            end
            checkOutput("l2_read_en", wide_t'(l2Bus.read_en), wide_t'(expInFlight));
            if (expInFlight) checkOutput("l2_addr", wide_t'(l2Bus.addr), wide_t'(curAddr));

            icPulse = (expIc.size() > 0 && expIc[0].cyc == cyc);
            checkOutput("ic_stall", wide_t'(icBus.stall), wide_t'(!icPulse));
            if (icPulse) begin
                d = expIc.pop_front();
                checkOutput("ic_block", icBus.block, d.block);
            end

            dcPulse = (expDc.size() > 0 && expDc[0].cyc == cyc);
            checkOutput("dc_stall", wide_t'(dcBus.stall), wide_t'(!dcPulse));
            if (dcPulse) begin
                d = expDc.pop_front();
                checkOutput("dc_block", dcBus.block, d.block);
            end

            if (expInFlight && !l2Bus.stall) expInFlight = 1'b0;
            icSawDone = !icBus.stall;
            dcSawDone = !dcBus.stall;
        end
    end

    // Random requesters: hold until served, occasionally abort or re-request immediately.
    always @(posedge clk) if (randOn) begin
        #1;
        if (icBus.read_en) begin
            if (icSawDone || $urandom_range(0, 31) == 0) begin
                if ($urandom_range(0, 3) == 0) icBus.addr = $urandom;
                else                            icBus.read_en = 1'b0;
            end
        end else if ($urandom_range(0, 2) == 0) begin
            icBus.read_en = 1'b1;
            icBus.addr    = $urandom;
        end
    end

    always @(posedge clk) if (randOn) begin
        #1;
        if (dcBus.read_en) begin
            if (dcSawDone || $urandom_range(0, 31) == 0) begin
                if ($urandom_range(0, 3) == 0) dcBus.addr = $urandom;
                else                            dcBus.read_en = 1'b0;
            end
        end else if ($urandom_range(0, 1) == 0) begin
            dcBus.read_en = 1'b1;
            dcBus.addr    = $urandom;
        end
    end

    always @(posedge clk) if (randOn) begin
        #1;
        l2Bus.stall = ($urandom_range(0, 2) != 0);
        l2Bus.block = randBlock();
    end

    initial begin
`ifdef L2_ARB_PERF_EN
        logic [31:0] ic0, dc0, wait0;
`endif
        rst_n         = 1'b0;
        icBus.read_en = 1'b0;
        icBus.addr    = '0;
        dcBus.read_en = 1'b0;
        dcBus.addr    = '0;
        l2Bus.stall   = 1'b1;
        l2Bus.block   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 0, 1);

        // Single icache miss with three L2 stall cycles.
        applyStimulus(1, 32'h0000_1040, 0, 0, 1);
        repeat (3) applyStimulus(1, 32'h0000_1040, 0, 0, 1);
        applyStimulus(1, 32'h0000_1040, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);

`ifdef L2_ARB_PERF_EN
        ic0   = perfIc;
        dc0   = perfDc;
        wait0 = perfWait;
`endif
        // Simultaneous requests with a zero-stall L2: dcache first, icache two cycles later.
        applyStimulus(1, 32'h0000_2000, 1, 32'h0000_8000, 0);
        applyStimulus(1, 32'h0000_2000, 1, 32'h0000_8000, 0);
        applyStimulus(1, 32'h0000_2000, 0, 0, 0);
        applyStimulus(1, 32'h0000_2000, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);
`ifdef L2_ARB_PERF_EN
        checkOutput("perf_ic_grants", wide_t'(perfIc - ic0), wide_t'(1));
        checkOutput("perf_dc_grants", wide_t'(perfDc - dc0), wide_t'(1));
        checkOutput("perf_wait_cycles", wide_t'(perfWait - wait0), wide_t'(2));
`endif

        // Starvation: dcache re-requests back to back while icache stays high.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i < 10, 32'h0000_3000, 1, 32'h0000_9000 + 32'(i / 2) * 32'h40, 0);
        end
        applyStimulus(0, 0, 0, 0, 1);

        // Abort: dcache gives up one cycle into BUSY while icache waits.
        applyStimulus(0, 0, 1, 32'h0000_A000, 1);
        applyStimulus(1, 32'h0000_5000, 1, 32'h0000_A000, 1);
        applyStimulus(1, 32'h0000_5000, 0, 0, 1);
        applyStimulus(1, 32'h0000_5000, 0, 0, 1);
        applyStimulus(1, 32'h0000_5000, 0, 0, 0);
        applyStimulus(1, 32'h0000_5000, 0, 0, 0);
        applyStimulus(1, 32'h0000_5000, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1);

        // Reset asserted in the middle of a BUSY phase must clear outputs immediately.
        applyStimulus(1, 32'h0000_7000, 0, 0, 1);
        applyStimulus(1, 32'h0000_7000, 0, 0, 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_l2_read_en", wide_t'(l2Bus.read_en), wide_t'(1'b0));
        checkOutput("async_rst_ic_stall", wide_t'(icBus.stall), wide_t'(1'b1));
        checkOutput("async_rst_dc_stall", wide_t'(dcBus.stall), wide_t'(1'b1));
        icBus.read_en = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_l2_addr", wide_t'(l2Bus.addr), wide_t'(0));
        applyStimulus(0, 0, 0, 0, 1);

        randOn = 1'b1;
        repeat (3000) @(posedge clk);
        randOn = 1'b0;
        repeat (12) applyStimulus(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
